spi_master_multi: RTL and testbench

Parametrised SPI master with configurable word length, SCLK divider and slave-select count. All four CPOL/CPHA modes and MSB/LSB-first order are selectable per transfer. The host side uses a valid/ready transmit handshake and a one-cycle receive strobe. The block sits between the APB register interface and the off-chip SPI pins, and performs full-duplex shifting on MOSI/MISO.

---
 rtl/spi_master_multi.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with configurable word length, SCLK divider
// and slave-select count; per-transfer CPOL/CPHA and bit order.
module spi_master_multi #(
    parameter int WORD_LENGTH      = 8,
    parameter int CLK_PER_HALF_BIT = 4,
    parameter int NUM_SS           = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       tx_valid,
    output logic                                       tx_ready,
    input  logic [WORD_LENGTH-1:0]                     tx_data,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
    input  logic                                       cpol,
    input  logic                                       cpha,
    input  logic                                       lsb_first,
    output logic                                       rx_valid,
    output logic [WORD_LENGTH-1:0]                     rx_data,
    output logic                                       busy,
    output logic                                       sclk,
    output logic                                       mosi,
    input  logic                                       miso,
    output logic [NUM_SS-1:0]                          ss_n
);

    localparam int W  = WORD_LENGTH;
    localparam int H  = CLK_PER_HALF_BIT;
    localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int CW = $clog2(H);
    localparam int EW = $clog2(2 * W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  rx_q, rx_d;
    logic [W-1:0]  rx_data_q, rx_data_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          cpol_q, cpol_d;
    logic          cpha_q, cpha_d;
    logic          lsb_q, lsb_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          rx_valid_q, rx_valid_d;

    logic tc;
    logic last_edge;
    logic lead;
    logic samp_en;
    logic drive_en;
    logic active;

    function automatic logic first_bit(input logic [W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[W-1];
    endfunction

    function automatic logic [W-1:0] advance(input logic [W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign tc        = (cnt_q == CW'(H - 1));
    assign last_edge = (edge_q == EW'(2 * W - 1));
    // edge_q counts edges already made, so an even count means a leading edge
    assign lead      = ~edge_q[0];
    assign samp_en   = (lead != cpha_q);
    assign drive_en  = ~samp_en & ~last_edge;
    assign active    = (state_q != S_IDLE);

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = active;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    // Next-state, shift and SCLK generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        sel_d      = sel_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (tx_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_d    = '0;
                    sel_d   = ss_sel;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    if (!cpha) begin
                        mosi_d = first_bit(tx_data, lsb_first);
                        tx_d   = advance(tx_data, lsb_first);
                    end else begin
                        tx_d = tx_data;
                    end
                end
            end
            S_SETUP: begin
                if (tc) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (tc) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (samp_en) begin
                        rx_d = lsb_q ? {miso, rx_q[W-1:1]}
                                     : {rx_q[W-2:0], miso};
                    end
                    if (drive_en) begin
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = advance(tx_q, lsb_q);
                    end
                    if (last_edge) begin
                        state_d = S_HOLD;
                        edge_d  = '0;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (tc) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Slave-select decode; out-of-range selects assert nothing
    always_comb begin
        ss_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (active && sel_q == SW'(i)) begin
                ss_n[i] = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            sel_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            sel_q      <= sel_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: vector table plus hand sequences for the SPI master,
// with a behavioural SPI slave and an rx scoreboard.
module tb_spi_master_multi;

    localparam int W = 8;
    localparam int H = 2;
    localparam int XC = 37;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] ret;
        logic [7:0] exp_rx;
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic       sel;
        logic       loop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [0:0] ss_sel;
    logic       cpol, cpha, lsb_first;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy, sclk, mosi, miso;
    logic [1:0] ss_n;

    logic       tx_valid2, tx_ready2, rx_valid2, busy2, sclk2, mosi2;
    logic [1:0] ss_sel2;
    logic [7:0] rx_data2;
    logic [2:0] ss_n2;

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic [3:0] tr[0:63];
    logic [3:0] tref[0:63];

    logic       s_cpol, s_cpha, s_lsb, loop;
    logic [7:0] s_word;
    logic [7:0] sl_cap;
    int         sl_i, sl_s;
    logic       miso_s = 1'b0;
    logic       ss_any;
    logic       ss_prev = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       lead;

    always #5 clk = ~clk;

    spi_master_multi #(.WORD_LENGTH(8), .CLK_PER_HALF_BIT(2), .NUM_SS(2)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    spi_master_multi #(.WORD_LENGTH(8), .CLK_PER_HALF_BIT(2), .NUM_SS(3)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data(tx_data), .ss_sel(ss_sel2), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .busy(busy2), .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .ss_n(ss_n2)
    );

    assign ss_any = (ss_n != 2'b11);
    assign miso   = loop ? mosi : miso_s;

    function automatic logic sbit(input int i);
        return s_lsb ? s_word[i] : s_word[W-1-i];
    endfunction

    // Behavioural slave: drives s_word, captures mosi, in the configured mode
    always @(ss_any or sclk) begin
        if (ss_any && !ss_prev) begin
            sl_i   = 0;
            sl_s   = 0;
            sl_cap = '0;
            miso_s = s_cpha ? 1'b0 : sbit(0);
        end else if (ss_any && sclk != sclk_prev) begin
            lead = (sclk != s_cpol);
            if (lead != s_cpha) begin
                if (sl_s < W) sl_cap[s_lsb ? sl_s : W-1-sl_s] = mosi;
                sl_s++;
            end else if (!s_cpha) begin
                sl_i++;
                if (sl_i < W) miso_s = sbit(sl_i);
            end else begin
                if (sl_i < W) miso_s = sbit(sl_i);
                sl_i++;
            end
        end
        ss_prev   = ss_any;
        sclk_prev = sclk;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic pop_check(input string nm);
        logic [7:0] e;
        if (q.size() == 0) begin
            check({nm, "_sb_empty"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            check(nm, 32'(rx_data), 32'(e));
        end
    endtask

    task automatic xfer(input vec_t v, input bit chg);
        int   n, edges, ss_err, bz_err, gap_err, last_t;
        logic prev;
        logic [1:0] exp_ss;
        exp_ss    = v.sel ? 2'b01 : 2'b10;
        s_cpol    = v.cpol;
        s_cpha    = v.cpha;
        s_lsb     = v.lsb;
        s_word    = v.ret;
        loop      = v.loop;
        cpol      = v.cpol;
        cpha      = v.cpha;
        lsb_first = v.lsb;
        ss_sel    = v.sel;
        tx_data   = v.tx;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_sclk", 32'(sclk), 32'(v.cpol));
        check("idle_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        q.push_back(v.exp_rx);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        if (chg) begin
            cpol      = ~cpol;
            cpha      = ~cpha;
            lsb_first = ~lsb_first;
            ss_sel    = ~ss_sel;
            tx_data   = ~tx_data;
        end
        prev = v.cpol;
        edges = 0; ss_err = 0; bz_err = 0; gap_err = 0; last_t = 0;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            tr[n] = {sclk, mosi, ss_n};
            if (sclk != prev) begin
                edges++;
                if (last_t != 0 && n - last_t != H) gap_err++;
                last_t = n;
            end
            prev = sclk;
            if (rx_valid) break;
            if (ss_n != exp_ss) ss_err++;
            if (!busy || tx_ready) bz_err++;
        end
        check("rx_cycle", n, XC);
        check("sclk_edges", edges, 16);
        check("sclk_halfper", gap_err, 0);
        check("ss_low", ss_err, 0);
        check("busy_win", bz_err, 0);
        check("end_ss_high", 32'(ss_n), 32'h3);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(tx_ready), 32'd1);
        check("end_sclk_idle", 32'(sclk), 32'(v.cpol));
        if (rx_valid) pop_check("rx_data");
        else q.delete();
        if (!v.loop) check("slave_cap", 32'(sl_cap), 32'(v.tx));
        @(negedge clk);
        check("rx_strobe_1cyc", 32'(rx_valid), 32'd0);
    endtask

    vec_t tab[4];
    vec_t vc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, edges, rv, d;
        logic prev;
        tab[0] = '{tx: 8'hA5, ret: 8'h00, exp_rx: 8'hA5, cpol: 0, cpha: 0, lsb: 0, sel: 0, loop: 1};
        tab[1] = '{tx: 8'h3C, ret: 8'h96, exp_rx: 8'h96, cpol: 1, cpha: 1, lsb: 1, sel: 0, loop: 0};
        tab[2] = '{tx: 8'h5A, ret: 8'hC3, exp_rx: 8'hC3, cpol: 0, cpha: 1, lsb: 0, sel: 1, loop: 0};
        tab[3] = '{tx: 8'hF0, ret: 8'h0E, exp_rx: 8'h0E, cpol: 1, cpha: 0, lsb: 1, sel: 1, loop: 0};
        vc     = '{tx: 8'hB2, ret: 8'h4D, exp_rx: 8'h4D, cpol: 0, cpha: 1, lsb: 0, sel: 0, loop: 0};

        rst = 1'b0; tx_valid = 1'b0; tx_valid2 = 1'b0;
        tx_data = '0; ss_sel = '0; ss_sel2 = '0;
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; loop = 1'b1;
        s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_word = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'h3);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_ss_n2", 32'(ss_n2), 32'h7);
        cpol = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) xfer(tab[i], 1'b0);

        // Back-to-back with tx_valid held high
        loop = 1'b1; cpol = 0; cpha = 0; lsb_first = 0; ss_sel = 0;
        @(negedge clk);
        tx_data = 8'h01; tx_valid = 1'b1; q.push_back(8'h01);
        @(posedge clk);
        #1;
        tx_data = 8'h02;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rx_valid) break;
        end
        check("b2b_first_cycle", n, XC);
        check("b2b_gap_ss_high", 32'(ss_n), 32'h3);
        pop_check("b2b_rx1");
        q.push_back(8'h02);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (m = 1; m <= 60; m++) begin
            @(negedge clk);
            if (m == 1) check("b2b_ss_relow", 32'(ss_n), 32'h2);
            if (rx_valid) break;
        end
        check("b2b_second_gap", m, XC);
        pop_check("b2b_rx2");

        // Reset after the fifth SCLK edge
        @(negedge clk);
        tx_data = 8'h77; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        prev = 1'b0; edges = 0;
        for (n = 1; n <= 60 && edges < 5; n++) begin
            @(negedge clk);
            if (sclk != prev) edges++;
            prev = sclk;
        end
        check("rst_mid_edges", edges, 5);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ss_n", 32'(ss_n), 32'h3);
        check("rst_mid_sclk", 32'(sclk), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(tx_ready), 32'd1);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rv = 0;
        repeat (50) begin
            @(negedge clk);
            if (rx_valid) rv++;
        end
        check("rst_mid_no_rx", rv, 0);
        xfer('{tx: 8'hC3, ret: 8'h00, exp_rx: 8'hC3, cpol: 0, cpha: 0, lsb: 0, sel: 0, loop: 1}, 1'b0);

        // Out-of-range select on the three-slave instance
        cpol = 0; cpha = 0; lsb_first = 0;
        tx_data = 8'h6B; ss_sel2 = 2'd3;
        @(negedge clk);
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        d = 0;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (ss_n2 != 3'b111) d++;
            if (rx_valid2) break;
        end
        check("oor_rx_cycle", n, XC);
        check("oor_ss_high", d, 0);
        check("oor_rx_data", 32'(rx_data2), 32'h6B);

        // Config inputs toggled after accept must not matter
        xfer(vc, 1'b0);
        for (int i = 0; i < 64; i++) tref[i] = tr[i];
        xfer(vc, 1'b1);
        d = 0;
        for (int i = 1; i <= XC; i++) if (tr[i] !== tref[i]) d++;
        check("cfg_trace", d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
